cnorm_bfp: RTL and testbench
============================

// Module: cnorm_bfp
// PURPOSE
//  Parametrised block-floating-point normaliser for the FFT datapath. Sits after each butterfly stage.
//  - Scales complex samples left by a shift code that is latched once per frame.
//  - Flags overflow: a live sticky flag plus a registered per-frame flag.
//  - Measures the frame's minimum sign headroom, used to select the next stage's shift.
//  - Optionally saturates instead of wrapping.
// PARAMETERS
//  NB        16  base data width; input width IW=NB+3, output width OW=NB+2
//  SW        2   shift-code width; legal shifts 0..2**SW-1
//  FRAME_LEN 64  samples per frame (power of 2, >=2)
// PORTS
//  CLK       in   1   clock, rising edge
//  RSTN      in   1   asynchronous active-low reset
//  ED        in   1   data enable; all state and outputs frozen when 0
//  START     in   1   marks sample 0 of a frame (qualified by ED)
//  SHIFT     in   SW  left-shift code, sampled only on START
//  DR, DI    in   IW  signed input real/imag
//  DOR, DOI  out  OW  signed normalised real/imag
//  RDY       out  1   START delayed one ED cycle (aligned with DOR/DOI of sample 0)
//  OVF       out  1   live sticky overflow of current frame
//  OVF_FRM   out  1   overflow result of last completed frame
//  FRM_DONE  out  1   one-cycle pulse aligned with last output sample of a frame
//  HEADROOM  out  SW  min redundant sign bits over last completed frame, saturated to 2**SW-1
// BEHAVIOUR
//  - Reset (RSTN=0, async): DOR/DOI/RDY/OVF/OVF_FRM/FRM_DONE/HEADROOM=0.
//    Frame counter=0, latched shift=0, idle. Reset mid-frame abandons the frame; no FRM_DONE.
//  - Only cycles with ED=1 advance anything. Latency is 1 ED cycle from DR/DI to DOR/DOI.
//  - Shift select: s = SHIFT when START=1 (that same sample uses it), else latched shift.
//  - Arithmetic: DOR = bits [IW-1:1] of (DR << s); DOI likewise. The LSB is dropped.
//  - Component overflow: input bits [IW-1:IW-1-s] not all equal. s=0 never overflows.
//  - OVF: on START, OVF <= overflow of that sample; otherwise OVF <= OVF | ovf(DR) | ovf(DI).
//  - Frame FSM, IDLE/RUN:
//    - IDLE: START -> RUN with cnt=1.
//    - RUN: each ED sample increments cnt. The sample at cnt=FRAME_LEN-1 ends the frame.
//      - Next cycle: FRM_DONE=1, OVF_FRM<=final OVF, HEADROOM<=frame min. FSM -> IDLE.
//    - START during RUN, including on the last sample, restarts the frame: cnt=1, OVF/min reset.
//      No FRM_DONE for the aborted frame.
//  - Headroom: per output component, count of leading bits equal to the sign bit, minus 1.
//    Frame min runs over both components of every sample; START reinitialises it.
//    Result is saturated to 2**SW-1.
//  - IDLE samples with ED=1 still pass through with the latched shift. They update DOR/DOI only,
//    not OVF/min/cnt. RDY=0 for them.
//  - RDY and FRM_DONE are single-cycle pulses; both fall on the next ED=1 cycle.
// CONFIGURATION
//  CNORM_SAT_EN defined:
//    - An overflowing component outputs the OW-bit extreme of the input sign:
//      positive -> 0x1FFFF, negative -> 0x20000 for NB=16.
//    - Non-overflowing components are unchanged.
//  Undefined: overflowing components wrap (plain bit slice).
//  OVF/OVF_FRM behaviour is identical in both builds.
// TESTING (NB=16, SW=2, FRAME_LEN=64)
//  1 Reset: assert RSTN=0 mid-frame with OVF=1 -> all outputs 0 immediately.
//    After release, no FRM_DONE until a new START plus 64 samples.
//  2 Scaling: START, SHIFT=2, DR=19'h00100, DI=19'h7FF00 ->
//    next cycle DOR=18'h00200, DOI=18'h3FE00, RDY=1, OVF=0.
//  3 Overflow: SHIFT=1, DR=19'h20000 ->
//    - OVF=1 in both builds.
//    - DOR=18'h20000 wrapped; DOR=18'h1FFFF with CNORM_SAT_EN.
//    - OVF_FRM=1 after frame end.
//  4 Headroom: 64 samples, SHIFT=0, max DR=19'h0FFFF, others small ->
//    FRM_DONE one cycle after sample 63, HEADROOM=2. All-zero frame -> HEADROOM=3.
//  5 Stall: ED=0 for 5 cycles mid-frame -> outputs and counter frozen.
//    FRM_DONE arrives exactly 5 cycles later than without the stall.
//  6 Restart: second START at sample 40 with SHIFT=3 ->
//    - No FRM_DONE at original sample 63; OVF cleared.
//    - FRM_DONE 64 samples after the second START, using shift 3 throughout.

Source files
------------

// File: rtl/cnorm_bfp_if.sv
// cnorm_bfp_if -- sample/result bundle for the block-floating-point normaliser.
//   master : drives ED, START, SHIFT, DR, DI; observes the results.
//   slave  : the normaliser itself.
// Signals:
//   ED        data enable (nothing advances while low)
//   START     sample 0 of a frame, qualified by ED
//   SHIFT     left-shift code, sampled on START only
//   DR, DI    signed input real/imag, NB+3 bits
//   DOR, DOI  signed normalised real/imag, NB+2 bits
//   RDY       START delayed one ED cycle
//   OVF       live sticky overflow of the current frame
//   OVF_FRM   overflow of the last completed frame
//   FRM_DONE  pulse aligned with the last output sample of a frame
//   HEADROOM  minimum redundant sign bits of the last completed frame
interface cnorm_bfp_if #(
  parameter int NB = 16,
  parameter int SW = 2
);
  localparam int IW = NB + 3;
  localparam int OW = NB + 2;

  logic          ED;
  logic          START;
  logic [SW-1:0] SHIFT;
  logic [IW-1:0] DR;
  logic [IW-1:0] DI;
  logic [OW-1:0] DOR;
  logic [OW-1:0] DOI;
  logic          RDY;
  logic          OVF;
  logic          OVF_FRM;
  logic          FRM_DONE;
  logic [SW-1:0] HEADROOM;

  modport master (
    output ED, START, SHIFT, DR, DI,
    input  DOR, DOI, RDY, OVF, OVF_FRM, FRM_DONE, HEADROOM
  );

  modport slave (
    input  ED, START, SHIFT, DR, DI,
    output DOR, DOI, RDY, OVF, OVF_FRM, FRM_DONE, HEADROOM
  );
endinterface

// File: rtl/cnorm_bfp.sv
// cnorm_bfp -- block-floating-point normaliser placed after each FFT butterfly stage.
// Scales complex samples left by a per-frame shift code, drops the LSB, flags overflow
// (live sticky and per-frame) and reports the frame's minimum sign headroom so the next
// stage can pick its shift.
// Ports:
//   CLK   clock, rising edge
//   RSTN  asynchronous active-low reset
//   bus   cnorm_bfp_if.slave (ED/START/SHIFT/DR/DI in, DOR/DOI/RDY/OVF/OVF_FRM/FRM_DONE/HEADROOM out)
// Build option:
//   CNORM_SAT_EN  when defined, an overflowing component clamps to the OW-bit extreme of its
//                 input sign instead of wrapping. Overflow flags are the same in both builds.

// Per-component datapath: shift, overflow detect, optional clamp, headroom count.
module cnorm_bfp_lane #(
  parameter int NB = 16,
  parameter int SW = 2
) (
  input  logic [NB+2:0] din,
  input  logic [SW-1:0] s,
  output logic [NB+1:0] dout,
  output logic          ovf,
  output logic [SW-1:0] hr
);
  localparam int IW   = NB + 3;
  localparam int OW   = NB + 2;
  localparam int HMAX = (2 ** SW) - 1;

  logic [OW-1:0] wrap;
  logic [IW-2:0] ovf_mask;
  logic          run;

  // Shift in IW bits, then drop the LSB; bits pushed past the MSB are lost.
  assign wrap = OW'((din << s) >> 1);

  // The top s bits below the sign must all match the sign, otherwise the value
  // does not survive the shift.
  assign ovf_mask = ~({(IW-1){1'b1}} >> s);
  assign ovf      = |((din[IW-2:0] ^ {(IW-1){din[IW-1]}}) & ovf_mask);

`ifdef CNORM_SAT_EN
  assign dout = !ovf        ? wrap :
                din[IW-1]   ? {1'b1, {(OW-1){1'b0}}} :
                              {1'b0, {(OW-1){1'b1}}};
`else
  assign dout = wrap;
`endif

  // Redundant sign bits of the output, counted from just below the MSB and
  // clamped at HMAX; only the top HMAX bits ever need inspecting.
  always_comb begin
    hr  = '0;
    run = 1'b1;
    for (int j = 0; j < HMAX; j++) begin
      if (run && (dout[OW-2-j] == dout[OW-1])) hr = hr + SW'(1);
      else                                     run = 1'b0;
    end
  end
endmodule

module cnorm_bfp #(
  parameter int NB        = 16,
  parameter int SW        = 2,
  parameter int FRAME_LEN = 64
) (
  input  logic        CLK,
  input  logic        RSTN,
  cnorm_bfp_if.slave  bus
);
  localparam int IW    = NB + 3;
  localparam int OW    = NB + 2;
  localparam int CW    = $clog2(FRAME_LEN);
  localparam int NLANE = 2;  // lane 0 = real, lane 1 = imag

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // ---------------- state ----------------
  logic [0:0]                      st_q;
  logic [CW-1:0]                   cnt_q;
  logic [SW-1:0]                   shl_q;
  logic                            ovf_q;
  logic [SW-1:0]                   min_q;
  logic [NLANE-1:0][OW-1:0]        dout_q;
  logic                            rdy_q;
  logic                            done_q;
  logic                            ovf_frm_q;
  logic [SW-1:0]                   hr_q;

  // ---------------- datapath ----------------
  logic [SW-1:0]                   s_sel;
  logic [NLANE-1:0][IW-1:0]        din;
  logic [NLANE-1:0][OW-1:0]        dout_c;
  logic [NLANE-1:0]                ovf_c;
  logic [NLANE-1:0][SW-1:0]        hr_c;

  // The START sample already uses the new shift code.
  assign s_sel = bus.START ? bus.SHIFT : shl_q;
  assign din   = {bus.DI, bus.DR};

  genvar g;
  generate
    for (g = 0; g < NLANE; g++) begin : g_lane
      cnorm_bfp_lane #(.NB(NB), .SW(SW)) u_lane (
        .din  (din[g]),
        .s    (s_sel),
        .dout (dout_c[g]),
        .ovf  (ovf_c[g]),
        .hr   (hr_c[g])
      );
    end
  endgenerate

  // ---------------- frame statistics ----------------
  logic          samp_ovf;
  logic [SW-1:0] samp_min;
  logic          ovf_nxt;
  logic [SW-1:0] min_nxt;
  logic          run_smp;
  logic          last;

  assign samp_ovf = |ovf_c;
  assign samp_min = (hr_c[0] < hr_c[1]) ? hr_c[0] : hr_c[1];

  // A START always reseeds the statistics, whether it opens a frame or aborts one.
  assign ovf_nxt  = bus.START ? samp_ovf : (ovf_q | samp_ovf);
  assign min_nxt  = bus.START ? samp_min :
                    (samp_min < min_q) ? samp_min : min_q;

  // Non-START sample inside a running frame; idle samples only pass through.
  assign run_smp  = (st_q == ST_RUN) && !bus.START;
  // A START on the final count aborts instead of completing the frame.
  assign last     = run_smp && (cnt_q == CW'(FRAME_LEN - 1));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      st_q      <= ST_IDLE;
      cnt_q     <= '0;
      shl_q     <= '0;
      ovf_q     <= 1'b0;
      min_q     <= '0;
      dout_q    <= '0;
      rdy_q     <= 1'b0;
      done_q    <= 1'b0;
      ovf_frm_q <= 1'b0;
      hr_q      <= '0;
    end else if (bus.ED) begin
      dout_q <= dout_c;
      rdy_q  <= bus.START;
      done_q <= last;
      if (bus.START) begin
        shl_q <= bus.SHIFT;
        st_q  <= ST_RUN;
        cnt_q <= CW'(1);
        ovf_q <= ovf_nxt;
        min_q <= min_nxt;
      end else if (run_smp) begin
        ovf_q <= ovf_nxt;
        min_q <= min_nxt;
        if (last) begin
          st_q      <= ST_IDLE;
          cnt_q     <= '0;
          ovf_frm_q <= ovf_nxt;
          hr_q      <= min_nxt;
        end else begin
          cnt_q <= cnt_q + CW'(1);
        end
      end
    end
  end

  // ---------------- outputs ----------------
  assign bus.DOR      = dout_q[0];
  assign bus.DOI      = dout_q[1];
  assign bus.RDY      = rdy_q;
  assign bus.OVF      = ovf_q;
  assign bus.OVF_FRM  = ovf_frm_q;
  assign bus.FRM_DONE = done_q;
  assign bus.HEADROOM = hr_q;
endmodule

// File: tb/tb_cnorm_bfp.sv
// tb_cnorm_bfp -- self-checking bench for cnorm_bfp (NB=16, SW=2, FRAME_LEN=64).
// Every ED=1 sample pushes the reference result onto a queue; it is popped and compared
// one clock later. A constant vector table covers the arithmetic; hand sequences cover
// reset, frame completion, stalls and restarts.
module tb_cnorm_bfp;
  localparam int NB = 16;
  localparam int SW = 2;
  localparam int IW = NB + 3;
  localparam int OW = NB + 2;
  localparam int FL = 64;

`ifdef CNORM_SAT_EN
  localparam logic [OW-1:0] OVP = 18'h1FFFF;
  localparam logic [OW-1:0] OVN = 18'h20000;
`else
  localparam logic [OW-1:0] OVP = 18'h20000;  // 20000<<1 wraps
  localparam logic [OW-1:0] OVN = 18'h04000;  // 71000<<3 wraps
`endif
`ifdef CNORM_SAT_EN
  localparam logic [OW-1:0] OVP3 = 18'h1FFFF;
`else
  localparam logic [OW-1:0] OVP3 = 18'h3FFFC; // 0FFFF<<3 wraps
`endif

  logic CLK = 1'b0;
  logic RSTN = 1'b0;
  always #5 CLK = ~CLK;

  cnorm_bfp_if #(.NB(NB), .SW(SW)) bus ();
  cnorm_bfp #(.NB(NB), .SW(SW), .FRAME_LEN(FL)) dut (.CLK(CLK), .RSTN(RSTN), .bus(bus));

  typedef struct {
    logic [OW-1:0] dor, doi;
    logic rdy, ovf, ovf_frm, done;
    logic [SW-1:0] hr;
  } exp_t;

  typedef struct {
    bit st; logic [SW-1:0] sh; logic [IW-1:0] dr, di;
    logic [OW-1:0] dor, doi; bit rdy, ovf;
  } vec_t;

  int checks = 0, failures = 0;
  int cyc = 0, ndone = 0, done_cyc = 0;
  exp_t sbq[$];
  exp_t held;

  // reference model state
  logic [SW-1:0] m_shl;
  bit m_run, m_ovf, m_ovf_frm;
  int m_cnt, m_min, m_hr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Arithmetic reference: multiply, range-test, halve.
  function automatic void mcomp(input logic [IW-1:0] d, input int s,
                                output logic [OW-1:0] o, output bit ov, output int hr);
    longint v, p, q, ol;
    v  = longint'($signed(d));
    p  = v * (longint'(1) << s);
    ov = (p > 262143) || (p < -262144);
    q  = p >>> 1;
    o  = q[OW-1:0];
`ifdef CNORM_SAT_EN
    if (ov) o = (v < 0) ? 18'h20000 : 18'h1FFFF;
`endif
    ol = longint'($signed(o));
    hr = 0;
    for (int r = 1; r <= 3; r++)
      if (ol >= -(longint'(1) << (OW-1-r)) && ol < (longint'(1) << (OW-1-r))) hr = r;
  endfunction

  function automatic void model(input bit st, input logic [SW-1:0] sh,
                                input logic [IW-1:0] dr, di, output exp_t e);
    int s, hr_r, hr_i, mn; bit ovr, ovi; logic [OW-1:0] orr, oii;
    s = st ? int'(sh) : int'(m_shl);
    if (st) m_shl = sh;
    mcomp(dr, s, orr, ovr, hr_r);
    mcomp(di, s, oii, ovi, hr_i);
    mn = (hr_r < hr_i) ? hr_r : hr_i;
    e.done = 1'b0;
    if (st) begin
      m_run = 1; m_cnt = 1; m_ovf = ovr | ovi; m_min = mn;
    end else if (m_run) begin
      m_ovf = m_ovf | ovr | ovi;
      if (mn < m_min) m_min = mn;
      if (m_cnt == FL - 1) begin
        m_run = 0; m_cnt = 0; e.done = 1'b1; m_ovf_frm = m_ovf; m_hr = m_min;
      end else m_cnt++;
    end
    e.dor = orr; e.doi = oii; e.rdy = st; e.ovf = m_ovf;
    e.ovf_frm = m_ovf_frm; e.hr = SW'(m_hr);
  endfunction

  task automatic model_reset();
    m_shl = '0; m_run = 0; m_ovf = 0; m_ovf_frm = 0; m_cnt = 0; m_min = 0; m_hr = 0;
    held = '{default: '0};
    sbq.delete();
  endtask

  function automatic logic [IW-1:0] rs(input int m);
    int v;
    logic [IW-1:0] r;
    v = int'($urandom_range(0, 2 * m)) - m;
    r = v[IW-1:0];
    return r;
  endfunction

  // One clock: drive at the falling edge, compare 1 ns after the rising edge.
  task automatic step(input bit ed, input bit st, input logic [SW-1:0] sh,
                      input logic [IW-1:0] dr, input logic [IW-1:0] di);
    exp_t e;
    bus.ED = ed; bus.START = st; bus.SHIFT = sh; bus.DR = dr; bus.DI = di;
    cyc++;
    if (ed) begin
      model(st, sh, dr, di, e);
      sbq.push_back(e);
    end
    @(posedge CLK); #1;
    if (ed) begin
      if (sbq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
      else held = sbq.pop_front();
    end
    chk("DOR", 32'(bus.DOR), 32'(held.dor));
    chk("DOI", 32'(bus.DOI), 32'(held.doi));
    chk("RDY", 32'(bus.RDY), 32'(held.rdy));
    chk("OVF", 32'(bus.OVF), 32'(held.ovf));
    chk("OVF_FRM", 32'(bus.OVF_FRM), 32'(held.ovf_frm));
    chk("FRM_DONE", 32'(bus.FRM_DONE), 32'(held.done));
    chk("HEADROOM", 32'(bus.HEADROOM), 32'(held.hr));
    if (ed && bus.FRM_DONE) begin ndone++; done_cyc = cyc; end
    @(negedge CLK);
  endtask

  vec_t vt[6];
  int t0, nd0;

  initial begin
    vt[0] = '{1, 2'd2, 19'h00100, 19'h7FF00, 18'h00200, 18'h3FE00, 1, 0};
    vt[1] = '{0, 2'd0, 19'h00001, 19'h7FFFF, 18'h00002, 18'h3FFFE, 0, 0};
    vt[2] = '{1, 2'd1, 19'h20000, 19'h00000, OVP,       18'h00000, 1, 1};
    vt[3] = '{0, 2'd3, 19'h00010, 19'h60000, 18'h00010, 18'h20000, 0, 1};
    vt[4] = '{1, 2'd0, 19'h7FFFF, 19'h00003, 18'h3FFFF, 18'h00001, 1, 0};
    vt[5] = '{1, 2'd3, 19'h0FFFF, 19'h71000, OVP3,      OVN,       1, 1};

    model_reset();
    bus.ED = 0; bus.START = 0; bus.SHIFT = '0; bus.DR = '0; bus.DI = '0;
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    #1;
    chk("rst_DOR", 32'(bus.DOR), 0);
    chk("rst_RDY", 32'(bus.RDY), 0);
    chk("rst_OVF", 32'(bus.OVF), 0);
    chk("rst_HEADROOM", 32'(bus.HEADROOM), 0);
    @(negedge CLK);

    // vector table: scaling, wrap/clamp, sticky overflow, shift latching
    for (int i = 0; i < 6; i++) begin
      step(1, vt[i].st, vt[i].sh, vt[i].dr, vt[i].di);
      chk($sformatf("vec%0d_DOR", i), 32'(bus.DOR), 32'(vt[i].dor));
      chk($sformatf("vec%0d_DOI", i), 32'(bus.DOI), 32'(vt[i].doi));
      chk($sformatf("vec%0d_RDY", i), 32'(bus.RDY), 32'(vt[i].rdy));
      chk($sformatf("vec%0d_OVF", i), 32'(bus.OVF), 32'(vt[i].ovf));
    end

    // reset mid-frame with OVF set: outputs clear at once, frame abandoned
    chk("pre_rst_OVF", 32'(bus.OVF), 1);
    #2 RSTN = 1'b0;
    #1;
    chk("arst_DOR", 32'(bus.DOR), 0);
    chk("arst_DOI", 32'(bus.DOI), 0);
    chk("arst_RDY", 32'(bus.RDY), 0);
    chk("arst_OVF", 32'(bus.OVF), 0);
    chk("arst_OVF_FRM", 32'(bus.OVF_FRM), 0);
    chk("arst_FRM_DONE", 32'(bus.FRM_DONE), 0);
    chk("arst_HEADROOM", 32'(bus.HEADROOM), 0);
    model_reset();
    @(negedge CLK);
    RSTN = 1'b1;
    nd0 = ndone;
    for (int i = 0; i < FL + 4; i++) step(1, 0, 2'd3, rs(5000), rs(5000));
    chk("idle_no_done", 32'(ndone - nd0), 0);

    // headroom frame: one large sample sets the minimum
    t0 = cyc + 1;
    for (int i = 0; i < FL; i++)
      step(1, i == 0, 2'd0, (i == 30) ? 19'h0FFFF : rs(100), rs(100));
    chk("hr_done_cyc", 32'(done_cyc - t0), FL - 1);
    chk("hr_HEADROOM", 32'(bus.HEADROOM), 2);
    chk("hr_OVF_FRM", 32'(bus.OVF_FRM), 0);
    step(1, 0, 2'd0, 19'h0, 19'h0);
    chk("done_pulse_fall", 32'(bus.FRM_DONE), 0);

    // all-zero frame saturates headroom
    for (int i = 0; i < FL; i++) step(1, i == 0, 2'd0, 19'h0, 19'h0);
    chk("zero_HEADROOM", 32'(bus.HEADROOM), 3);

    // overflow frame
    for (int i = 0; i < FL; i++)
      step(1, i == 0, 2'd1, (i == 10) ? 19'h20000 : rs(100), rs(100));
    chk("ovf_OVF_FRM", 32'(bus.OVF_FRM), 1);

    // stall: 5 ED=0 cycles mid-frame push FRM_DONE out by 5
    t0 = cyc + 1;
    for (int i = 0; i < 20; i++) step(1, i == 0, 2'd0, rs(1000), rs(1000));
    for (int i = 0; i < 5; i++)  step(0, 1, 2'd3, rs(50000), rs(50000));
    for (int i = 20; i < FL; i++) step(1, 0, 2'd0, rs(1000), rs(1000));
    chk("stall_done_cyc", 32'(done_cyc - t0), FL - 1 + 5);

    // restart at sample 40 with shift 3 clears OVF and aborts the first frame
    nd0 = ndone;
    for (int i = 0; i < 40; i++)
      step(1, i == 0, 2'd1, (i == 5) ? 19'h20000 : rs(1000), rs(1000));
    chk("rs_pre_OVF", 32'(bus.OVF), 1);
    t0 = cyc + 1;
    step(1, 1, 2'd3, rs(1000), rs(1000));
    chk("rs_OVF_clr", 32'(bus.OVF), 0);
    for (int i = 1; i < FL; i++) step(1, 0, 2'd0, rs(1000), rs(1000));
    chk("rs_ndone", 32'(ndone - nd0), 1);
    chk("rs_done_cyc", 32'(done_cyc - t0), FL - 1);

    // START on the final sample aborts that frame too
    nd0 = ndone;
    for (int i = 0; i < FL - 1; i++) step(1, i == 0, 2'd0, rs(1000), rs(1000));
    step(1, 1, 2'd2, rs(1000), rs(1000));
    chk("last_start_no_done", 32'(ndone - nd0), 0);
    for (int i = 1; i < FL; i++) step(1, 0, 2'd0, rs(1000), rs(1000));
    chk("last_start_done", 32'(ndone - nd0), 1);

    chk("sb_drained", 32'(sbq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
